// File: rtl/selector_4_1.sv
// selector_4_1: registered 4-to-1 channel selector.
// On each enabled rising edge the channel picked by {iS1,iS0} is captured
// into oZ along with the select code. oValid tracks the enable of the most
// recent edge. oChg pulses for one cycle when a capture changes oZ.
// Every output comes straight from a flop, so there is no combinational
// path from any input to any output.
module selector_4_1 #(
   parameter int WIDTH = 4
) (
   input  logic             iClk,
   input  logic             iRst_n,
   input  logic             iEn,
   input  logic [WIDTH-1:0] iC0,
   input  logic [WIDTH-1:0] iC1,
   input  logic [WIDTH-1:0] iC2,
   input  logic [WIDTH-1:0] iC3,
   input  logic             iS1,
   input  logic             iS0,
   output logic [WIDTH-1:0] oZ,
   output logic [1:0]       oSel,
   output logic             oValid,
   output logic             oChg
);

   localparam logic [1:0] SEL_C0 = 2'b00;
   localparam logic [1:0] SEL_C1 = 2'b01;
   localparam logic [1:0] SEL_C2 = 2'b10;
   localparam logic [1:0] SEL_C3 = 2'b11;

   logic [1:0]       sel_code;
   logic [WIDTH-1:0] mux_data;

   logic [WIDTH-1:0] z_q,     z_d;
   logic [1:0]       sel_q,   sel_d;
   logic             valid_q, valid_d;
   logic             chg_q,   chg_d;

   assign sel_code = {iS1, iS0};

   // Pick the channel addressed by the select code.
   always_comb begin
      // NOTE: give every always_comb output a default before the branches;
      // a path that leaves a variable unassigned would infer a latch.
      mux_data = iC0;
      case (sel_code)
         SEL_C0:  mux_data = iC0;
         SEL_C1:  mux_data = iC1;
         SEL_C2:  mux_data = iC2;
         SEL_C3:  mux_data = iC3;
         default: mux_data = iC0;
      endcase
   end

   // Work out the next state. Disabled edges hold the data and the select
   // code and clear the change pulse. The change pulse compares the new
   // capture against the value currently held, which is zero after reset.
   always_comb begin
      z_d     = z_q;
      sel_d   = sel_q;
      valid_d = iEn;
      chg_d   = 1'b0;
      if (iEn) begin
         z_d   = mux_data;
         sel_d = sel_code;
         chg_d = (mux_data != z_q);
      end
   end

   // Update the state registers. Reset takes effect at once, without a clock.
   always_ff @(posedge iClk or negedge iRst_n) begin
      if (!iRst_n) begin
         z_q     <= '0;
         sel_q   <= 2'b00;
         valid_q <= 1'b0;
         chg_q   <= 1'b0;
      end else begin
         // NOTE: use non-blocking assignments for flops, so that every
         // register samples values from before the edge whatever the
         // statement order.
         z_q     <= z_d;
         sel_q   <= sel_d;
         valid_q <= valid_d;
         chg_q   <= chg_d;
      end
   end

   assign oZ     = z_q;
   assign oSel   = sel_q;
   assign oValid = valid_q;
   assign oChg   = chg_q;

endmodule

// File: tb/tb_selector_4_1.sv
// tb_selector_4_1: self-checking bench for selector_4_1.
// A small behavioural model picks the expected output from an array of
// channels indexed by the select code. It is updated at each edge from the
// inputs applied for that edge.
module tb_selector_4_1;

   localparam int WIDTH = 4;

   logic             clk;
   logic             rst_n;
   logic             en;
   logic             s1, s0;
   logic [WIDTH-1:0] c [4];

   logic [WIDTH-1:0] oz;
   logic [1:0]       osel;
   logic             ovalid;
   logic             ochg;

   // Expected values from the model.
   logic [WIDTH-1:0] m_z;
   logic [1:0]       m_sel;
   logic             m_valid;
   logic             m_chg;

   int checks = 0;
   int errors = 0;

   selector_4_1 #(.WIDTH(WIDTH)) dut (
      .iClk   (clk),
      .iRst_n (rst_n),
      .iEn    (en),
      .iC0    (c[0]),
      .iC1    (c[1]),
      .iC2    (c[2]),
      .iC3    (c[3]),
      .iS1    (s1),
      .iS0    (s0),
      .oZ     (oz),
      .oSel   (osel),
      .oValid (ovalid),
      .oChg   (ochg)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drive every input for the next edge.
   task automatic drive(input logic e, input logic [1:0] s,
                        input logic [WIDTH-1:0] d0, input logic [WIDTH-1:0] d1,
                        input logic [WIDTH-1:0] d2, input logic [WIDTH-1:0] d3);
      en   = e;
      s1   = s[1];
      s0   = s[0];
      c[0] = d0;
      c[1] = d1;
      c[2] = d2;
      c[3] = d3;
   endtask

   task automatic model_reset();
      m_z     = '0;
      m_sel   = 2'b00;
      m_valid = 1'b0;
      m_chg   = 1'b0;
   endtask

   // Work out what one rising edge does, using the inputs now applied.
   task automatic model_edge();
      logic [WIDTH-1:0] picked;
      picked = c[{s1, s0}];
      if (en) begin
         m_chg = (picked != m_z);
         m_z   = picked;
         m_sel = {s1, s0};
      end else begin
         m_chg = 1'b0;
      end
      m_valid = en;
   endtask

   // Advance one edge (model first, then the DUT) and sample 1 ns later.
   task automatic tick();
      model_edge();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      drive(1'b1, 2'b11, 4'hF, 4'hF, 4'hF, 4'hF);
      model_reset();
      #1;
      for (int i = 0; i < 3; i++) begin
         checks++;
         if ({oz, osel, ovalid, ochg} !== {m_z, m_sel, m_valid, m_chg}) begin
            errors++;
            $display("FAIL reset_hold[%0d]: got z=%b sel=%b v=%b chg=%b, want z=%b sel=%b v=%b chg=%b",
                     i, oz, osel, ovalid, ochg, m_z, m_sel, m_valid, m_chg);
         end
         @(posedge clk);
         #1;
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_directed();
      // Capture channel 3 from the reset state.
      drive(1'b1, 2'b11, 4'b0000, 4'b0000, 4'b0000, 4'b0001);
      tick();
      checks++;
      if ({oz, osel, ovalid, ochg} !== {4'b0001, 2'b11, 1'b1, 1'b1}) begin
         errors++;
         $display("FAIL first_capture: got z=%b sel=%b v=%b chg=%b, want z=0001 sel=11 v=1 chg=1",
                  oz, osel, ovalid, ochg);
      end
      // Select a different channel that holds the same value: no change pulse.
      drive(1'b1, 2'b01, 4'b0000, 4'b0001, 4'b0000, 4'b0000);
      tick();
      checks++;
      if ({oz, osel, ovalid, ochg} !== {4'b0001, 2'b01, 1'b1, 1'b0}) begin
         errors++;
         $display("FAIL same_value: got z=%b sel=%b v=%b chg=%b, want z=0001 sel=01 v=1 chg=0",
                  oz, osel, ovalid, ochg);
      end
      drive(1'b1, 2'b10, 4'b0000, 4'b0000, 4'b0001, 4'b0000);
      tick();
      checks++;
      if ({oz, osel, ochg} !== {4'b0001, 2'b10, 1'b0}) begin
         errors++;
         $display("FAIL sel10: got z=%b sel=%b chg=%b, want z=0001 sel=10 chg=0", oz, osel, ochg);
      end
      drive(1'b1, 2'b00, 4'b0000, 4'b0000, 4'b0001, 4'b0000);
      tick();
      checks++;
      if ({oz, osel, ochg} !== {4'b0000, 2'b00, 1'b1}) begin
         errors++;
         $display("FAIL sel00: got z=%b sel=%b chg=%b, want z=0000 sel=00 chg=1", oz, osel, ochg);
      end
   endtask

   task automatic test_hold();
      // Put a known value in the register first.
      drive(1'b1, 2'b10, 4'h0, 4'h0, 4'h6, 4'h0);
      tick();
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, 2'($urandom_range(0, 3)), 4'($urandom), 4'($urandom),
               4'($urandom), 4'($urandom));
         tick();
         checks++;
         if ({oz, osel, ovalid, ochg} !== {4'h6, 2'b10, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL hold[%0d]: got z=%b sel=%b v=%b chg=%b, want z=0110 sel=10 v=0 chg=0",
                     i, oz, osel, ovalid, ochg);
         end
      end
   endtask

   task automatic test_async_reset();
      drive(1'b1, 2'b11, 4'b0000, 4'b0000, 4'b0000, 4'b0001);
      tick();
      // Assert reset between edges; the outputs must clear before the next edge.
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      checks++;
      if ({oz, osel, ovalid, ochg} !== {4'b0000, 2'b00, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL async_reset: got z=%b sel=%b v=%b chg=%b, want all zero",
                  oz, osel, ovalid, ochg);
      end
      // Clock edges during reset must be ignored.
      drive(1'b1, 2'b01, 4'h0, 4'h9, 4'h0, 4'h0);
      @(posedge clk);
      #1;
      checks++;
      if ({oz, osel, ovalid, ochg} !== {4'b0000, 2'b00, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL reset_ignores_clk: got z=%b sel=%b v=%b chg=%b, want all zero",
                  oz, osel, ovalid, ochg);
      end
      @(negedge clk);
      rst_n = 1'b1;
      // The first capture after release compares against zero, not the old 0001.
      drive(1'b1, 2'b00, 4'b0000, 4'b0000, 4'b0000, 4'b0001);
      tick();
      checks++;
      if ({oz, osel, ovalid, ochg} !== {4'b0000, 2'b00, 1'b1, 1'b0}) begin
         errors++;
         $display("FAIL post_reset_capture: got z=%b sel=%b v=%b chg=%b, want z=0000 sel=00 v=1 chg=0",
                  oz, osel, ovalid, ochg);
      end
   endtask

   task automatic test_exhaustive();
      logic [WIDTH-1:0] want;
      for (int s = 0; s < 4; s++) begin
         drive(1'b1, 2'(s), 4'b0001, 4'b0010, 4'b0100, 4'b1000);
         tick();
         want = WIDTH'(1 << s);
         checks++;
         if (oz !== want || osel !== 2'(s) || ochg !== m_chg) begin
            errors++;
            $display("FAIL exhaustive[sel=%0d]: got z=%b sel=%b chg=%b, want z=%b sel=%b chg=%b",
                     s, oz, osel, ochg, want, 2'(s), m_chg);
         end
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 300; i++) begin
         // Small data values make equal captures (no change pulse) common.
         drive(($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
               4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
               4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)));
         tick();
         checks++;
         if ({oz, osel, ovalid, ochg} !== {m_z, m_sel, m_valid, m_chg}) begin
            errors++;
            $display("FAIL random[%0d]: got z=%b sel=%b v=%b chg=%b, want z=%b sel=%b v=%b chg=%b",
                     i, oz, osel, ovalid, ochg, m_z, m_sel, m_valid, m_chg);
         end
         // Inputs changing between edges must not reach the outputs.
         drive(~en, ~{s1, s0}, ~c[0], ~c[1], ~c[2], ~c[3]);
         #2;
         checks++;
         if ({oz, osel, ovalid, ochg} !== {m_z, m_sel, m_valid, m_chg}) begin
            errors++;
            $display("FAIL between_edges[%0d]: got z=%b sel=%b v=%b chg=%b, want z=%b sel=%b v=%b chg=%b",
                     i, oz, osel, ovalid, ochg, m_z, m_sel, m_valid, m_chg);
         end
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_hold();
      test_async_reset();
      test_exhaustive();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Stop a stuck run with a failure line instead of letting it hang.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
